// File: rtl/psram_dev_rsp.sv
// ---------------------------------------------------------------------------
// psram_dev_rsp
//
// Memory-side end of a QSPI PSRAM link. The controller's SCK, CE and IO pads
// are oversampled on the fast system clock, the command/address/wait phases
// are decoded, and quad reads and writes are served from an internal byte
// array. Single data rate, 4-bit IO, MSB nibble first.
//
// Parameters
//   MEM_DEPTH  bytes of storage, power of two, at least 32
//   WR_CMD     quad write opcode
//   RD_CMD     quad read opcode
//   RD_WAIT    SCK rising edges between the last address nibble and the
//              first read data nibble
//
// Ports
//   clk_i            system clock, at least 8x the SCK frequency
//   rst_n_i          asynchronous active-low reset
//   psram_sck_i      serial clock from the controller
//   psram_ce_i       chip enable from the controller, active low
//   psram_io_in_i    4-bit data from the controller
//   psram_io_out_o   4-bit data to the controller
//   psram_io_en_o    responder drives IO when high
//   psram_dqs_out_o  read strobe, toggles with every output nibble
//   psram_dqs_en_o   strobe drive enable, same as psram_io_en_o
//   busy_o           a transaction is in progress (synchronized CE low)
//   cmd_err_o        one-cycle pulse when an unknown opcode is decoded
// ---------------------------------------------------------------------------
module psram_dev_rsp #(
  parameter int         MEM_DEPTH = 4096,
  parameter logic [7:0] WR_CMD    = 8'h38,
  parameter logic [7:0] RD_CMD    = 8'hEB,
  parameter int         RD_WAIT   = 6
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       psram_sck_i,
  input  logic       psram_ce_i,
  input  logic [3:0] psram_io_in_i,
  output logic [3:0] psram_io_out_o,
  output logic       psram_io_en_o,
  output logic       psram_dqs_out_o,
  output logic       psram_dqs_en_o,
  output logic       busy_o,
  output logic       cmd_err_o
);

  localparam int            AW        = $clog2(MEM_DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [7:0]    WAIT_LAST = (RD_WAIT == 0) ? 8'd0 : 8'(RD_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_ADDR,
    S_WAIT,
    S_RDATA,
    S_WDATA,
    S_SKIP
  } state_t;

  state_t state, state_nxt;

  logic       sck_meta, sck_sync, sck_prev;
  logic       ce_meta, ce_sync;
  logic [3:0] io_meta, io_sync;
  logic       sck_rise, sck_fall;

  logic [2:0]    nib_cnt;
  logic [7:0]    wait_cnt;
  logic [3:0]    cmd_hi;
  logic          is_rd;
  logic [AW-1:0] ptr;
  logic [3:0]    wr_hi;
  logic          wr_phase;
  logic          rd_phase;
  logic          io_en;

  logic [7:0] opcode;
  logic       opcode_known;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic [7:0] rd_data;

  logic [7:0] mem [MEM_DEPTH];

  // Two-flop synchronizers on every pad, plus one extra SCK stage so the
  // edge detectors compare two synchronized samples. CE resets to the
  // deselected level so busy_o reads 0 out of reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sck_meta <= 1'b0;
      sck_sync <= 1'b0;
      sck_prev <= 1'b0;
      ce_meta  <= 1'b1;
      ce_sync  <= 1'b1;
      io_meta  <= 4'h0;
      io_sync  <= 4'h0;
    end else begin
      sck_meta <= psram_sck_i;
      sck_sync <= sck_meta;
      sck_prev <= sck_sync;
      ce_meta  <= psram_ce_i;
      ce_sync  <= ce_meta;
      io_meta  <= psram_io_in_i;
      io_sync  <= io_meta;
    end
  end

  assign sck_rise = sck_sync & ~sck_prev;
  assign sck_fall = ~sck_sync & sck_prev;

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. A deselected CE overrides everything, so a transfer
  // can be cut off at any nibble and the next CE-low starts from scratch.
  always_comb begin
    state_nxt = state;
    if (ce_sync) begin
      state_nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:  state_nxt = S_CMD;
        S_CMD: begin
          if (sck_rise && nib_cnt == 3'd1) begin
            state_nxt = opcode_known ? S_ADDR : S_SKIP;
          end
        end
        S_ADDR: begin
          if (sck_rise && nib_cnt == 3'd5) begin
            if (!is_rd) begin
              state_nxt = S_WDATA;
            end else if (RD_WAIT == 0) begin
              state_nxt = S_RDATA;
            end else begin
              state_nxt = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (sck_rise && wait_cnt == WAIT_LAST) begin
            state_nxt = S_RDATA;
          end
        end
        default: state_nxt = state;
      endcase
    end
  end

  // Combinational outputs and decode helpers. The opcode is formed from the
  // stored high nibble and the nibble arriving on the second command edge.
  // A write strobe fires only on the low nibble, so a half-received byte at
  // CE-high never reaches the array.
  always_comb begin
    opcode         = {cmd_hi, io_sync};
    opcode_known   = (opcode == WR_CMD) || (opcode == RD_CMD);
    mem_we         = (state == S_WDATA) && sck_rise && wr_phase && !ce_sync;
    mem_wdata      = {wr_hi, io_sync};
    busy_o         = ~ce_sync;
    psram_io_en_o  = io_en;
    psram_dqs_en_o = io_en;
  end

  // Phase datapath: counters, shift registers, pointer and the registered
  // read-side pad outputs. The pointer is loaded by shifting the address
  // nibbles straight in, so only the low AW address bits survive and the
  // upper address bits alias naturally.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      nib_cnt         <= 3'd0;
      wait_cnt        <= 8'd0;
      cmd_hi          <= 4'h0;
      is_rd           <= 1'b0;
      ptr             <= '0;
      wr_hi           <= 4'h0;
      wr_phase        <= 1'b0;
      rd_phase        <= 1'b0;
      io_en           <= 1'b0;
      psram_io_out_o  <= 4'h0;
      psram_dqs_out_o <= 1'b0;
      cmd_err_o       <= 1'b0;
    end else begin
      cmd_err_o <= 1'b0;
      if (ce_sync) begin
        nib_cnt         <= 3'd0;
        wait_cnt        <= 8'd0;
        wr_phase        <= 1'b0;
        rd_phase        <= 1'b0;
        io_en           <= 1'b0;
        psram_io_out_o  <= 4'h0;
        psram_dqs_out_o <= 1'b0;
      end else begin
        case (state)
          S_CMD: begin
            if (sck_rise) begin
              cmd_hi  <= io_sync;
              nib_cnt <= nib_cnt + 3'd1;
              if (nib_cnt == 3'd1) begin
                nib_cnt   <= 3'd0;
                is_rd     <= (opcode == RD_CMD);
                cmd_err_o <= ~opcode_known;
              end
            end
          end
          S_ADDR: begin
            if (sck_rise) begin
              ptr      <= {ptr[AW-5:0], io_sync};
              nib_cnt  <= (nib_cnt == 3'd5) ? 3'd0 : nib_cnt + 3'd1;
              wait_cnt <= 8'd0;
            end
          end
          S_WAIT: begin
            if (sck_rise) begin
              wait_cnt <= wait_cnt + 8'd1;
            end
          end
          S_RDATA: begin
            if (sck_fall) begin
              io_en           <= 1'b1;
              psram_dqs_out_o <= ~psram_dqs_out_o;
              rd_phase        <= ~rd_phase;
              if (!rd_phase) begin
                psram_io_out_o <= rd_data[7:4];
              end else begin
                psram_io_out_o <= rd_data[3:0];
                ptr            <= ptr + PTR_ONE;
              end
            end
          end
          S_WDATA: begin
            if (sck_rise) begin
              wr_phase <= ~wr_phase;
              if (!wr_phase) begin
                wr_hi <= io_sync;
              end else begin
                ptr <= ptr + PTR_ONE;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  // Synchronous-read byte array. The read port follows the pointer every
  // cycle, so the byte for the next SCK fall is ready one clock after the
  // pointer moves; the clock ratio leaves several cycles of margin.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem[ptr] <= mem_wdata;
    end
    rd_data <= mem[ptr];
  end

endmodule
